// File: rtl/alu_frame_builder.sv
// alu_frame_builder: buffers ALU result words and emits them as length-delimited frames with sof/eof.
// Latency: request accepted at edge T with data present -> first beat visible in cycle T+2.
// Backpressure: frame_hold freezes the current beat; frame_bp flags a nearly full FIFO.

// alu_frame_fifo: generic power-of-2 FIFO with occupancy count, writes dropped when full.
// Latency: a write is visible in count the cycle after its edge; rd_dat shows the head combinationally.
// Backpressure: none internally; the owner must not pop when empty and must watch count for full.
module alu_frame_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_pop,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_en;
    logic          rd_en;

    assign wr_en  = wr_vld && (count != FULL_CNT);
    assign rd_en  = rd_pop && (count != '0);
    assign rd_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (rd_en) rptr <= rptr + PTR_ONE;
            if (wr_en && !rd_en)      count <= count + CNT_ONE;
            else if (rd_en && !wr_en) count <= count - CNT_ONE;
        end
    end
endmodule

module alu_frame_builder #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int LEN_W     = 6,
    parameter int BP_THRESH = DEPTH - 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LEN_W-1:0]         frame_len,
    input  logic                     frame_len_val,
    output logic                     frame_len_rdy,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     alu_ready,
    output logic                     frame,
    output logic [DATA_W-1:0]        frame_data,
    output logic                     frame_sof,
    output logic                     frame_eof,
    input  logic                     frame_hold,
    output logic                     frame_bp,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_ovf,
    output logic                     err_len0
);
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {IDLE, PENDING, FRAMING} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic              first_beat;
    logic              accept;
    logic              pop;
    logic [DATA_W-1:0] rd_dat;
    logic              cnt_ge_len;
    logic              cnt_ge_rem;
    logic              fifo_full;

    alu_frame_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (alu_ready),
        .wr_dat (alu_data),
        .rd_pop (pop),
        .rd_dat (rd_dat),
        .count  (fifo_count)
    );

    // Length checks use the registered count, so a same-cycle write never counts.
    assign cnt_ge_len = 32'(fifo_count) >= 32'(frame_len);
    assign cnt_ge_rem = 32'(fifo_count) >= 32'(remaining);
    assign fifo_full  = 32'(fifo_count) == DEPTH;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && frame_len != '0) state_nxt = cnt_ge_len ? FRAMING : PENDING;
            PENDING: if (cnt_ge_rem) state_nxt = FRAMING;
            FRAMING: if (pop && remaining == LEN_ONE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_len_rdy = (state == IDLE) && !rst;
        accept        = frame_len_val && frame_len_rdy;
        pop           = (state == FRAMING) && (remaining != '0) && (!frame || !frame_hold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            first_beat <= 1'b0;
            frame      <= 1'b0;
            frame_data <= '0;
            frame_sof  <= 1'b0;
            frame_eof  <= 1'b0;
            frame_bp   <= 1'b0;
            err_ovf    <= 1'b0;
            err_len0   <= 1'b0;
        end else begin
            if (accept) begin
                remaining  <= frame_len;
                first_beat <= 1'b1;
            end else if (pop) begin
                remaining  <= remaining - LEN_ONE;
                first_beat <= 1'b0;
            end
            // A held beat keeps every output field; an unheld beat retires unless replaced.
            if (pop) begin
                frame      <= 1'b1;
                frame_data <= rd_dat;
                frame_sof  <= first_beat;
                frame_eof  <= (remaining == LEN_ONE);
            end else if (!frame_hold) begin
                frame     <= 1'b0;
                frame_sof <= 1'b0;
                frame_eof <= 1'b0;
            end
            frame_bp <= 32'(fifo_count) >= BP_THRESH;
            if (alu_ready && fifo_full)         err_ovf  <= 1'b1;
            if (accept && frame_len == '0)      err_len0 <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_frame_builder.sv
// Directed bench for alu_frame_builder: table of frame transactions plus
// hand-written sequences for pending, hold, overflow, zero length and reset.
module tb_alu_frame_builder;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int LEN_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_len_val;
    logic              frame_len_rdy;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              frame;
    logic [DATA_W-1:0] frame_data;
    logic              frame_sof;
    logic              frame_eof;
    logic              frame_hold;
    logic              frame_bp;
    logic [5:0]        fifo_count;
    logic              err_ovf;
    logic              err_len0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          nw;
        logic [31:0] wbase;
        int          len;
        logic [31:0] first;
        int          cnt_before;
        int          cnt_after;
    } vec_t;

    vec_t vecs[5];

    alu_frame_builder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_len     (frame_len),
        .frame_len_val (frame_len_val),
        .frame_len_rdy (frame_len_rdy),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .frame         (frame),
        .frame_data    (frame_data),
        .frame_sof     (frame_sof),
        .frame_eof     (frame_eof),
        .frame_hold    (frame_hold),
        .frame_bp      (frame_bp),
        .fifo_count    (fifo_count),
        .err_ovf       (err_ovf),
        .err_len0      (err_len0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            alu_data  = base + 32'(i);
            alu_ready = 1'b1;
            step();
        end
        alu_ready = 1'b0;
    endtask

    task automatic request(input int len);
        frame_len     = LEN_W'(len);
        frame_len_val = 1'b1;
        step();
        frame_len_val = 1'b0;
    endtask

    // Starts in the cycle where beat 'from' is visible; ends one cycle after the last beat.
    task automatic expect_beats(input logic [31:0] first, input int len, input int from);
        for (int i = from; i < len; i++) begin
            check("beat_vld", frame, 1);
            check("beat_dat", frame_data, first + 32'(i));
            check("beat_sof", frame_sof, 32'(i == 0));
            check("beat_eof", frame_eof, 32'(i == len - 1));
            if (i == len - 1) check("rdy_at_eof", frame_len_rdy, 1);
            step();
        end
        check("frame_end", frame, 0);
    endtask

    task automatic run_frame(input vec_t v);
        write_words(v.wbase, v.nw);
        check("cnt_before", fifo_count, v.cnt_before);
        request(v.len);
        check("no_frame_t1", frame, 0);
        step();
        expect_beats(v.first, v.len, 0);
        check("cnt_after", fifo_count, v.cnt_after);
    endtask

    initial begin
        vecs[0] = '{nw: 4, wbase: 32'hA0, len: 4, first: 32'hA0, cnt_before: 4, cnt_after: 0};
        vecs[1] = '{nw: 1, wbase: 32'hB0, len: 1, first: 32'hB0, cnt_before: 1, cnt_after: 0};
        vecs[2] = '{nw: 7, wbase: 32'hC0, len: 3, first: 32'hC0, cnt_before: 7, cnt_after: 4};
        vecs[3] = '{nw: 0, wbase: 32'h00, len: 4, first: 32'hC3, cnt_before: 4, cnt_after: 0};
        vecs[4] = '{nw: 2, wbase: 32'hD0, len: 2, first: 32'hD0, cnt_before: 2, cnt_after: 0};

        rst           = 1'b1;
        frame_len     = '0;
        frame_len_val = 1'b0;
        alu_data      = '0;
        alu_ready     = 1'b0;
        frame_hold    = 1'b0;
        step();
        step();
        check("rst_frame", frame, 0);
        check("rst_data", frame_data, 0);
        check("rst_sof", frame_sof, 0);
        check("rst_eof", frame_eof, 0);
        check("rst_count", fifo_count, 0);
        check("rst_bp", frame_bp, 0);
        check("rst_ovf", err_ovf, 0);
        check("rst_len0", err_len0, 0);
        check("rst_rdy", frame_len_rdy, 0);
        rst = 1'b0;
        #1;
        check("idle_rdy", frame_len_rdy, 1);

        for (int v = 0; v < 5; v++) run_frame(vecs[v]);

        // Zero-length request, then a single-beat frame accepted the very next cycle.
        write_words(32'hE0, 1);
        request(0);
        check("len0_err", err_len0, 1);
        check("len0_rdy", frame_len_rdy, 1);
        check("len0_frame", frame, 0);
        request(1);
        check("len1_t1", frame, 0);
        step();
        expect_beats(32'hE0, 1, 0);
        check("len1_cnt", fifo_count, 0);

        // Pending: request ahead of data, frame starts two cycles after count reaches 6.
        write_words(32'h60, 2);
        request(6);
        check("pend_rdy", frame_len_rdy, 0);
        check("pend_frame0", frame, 0);
        step();
        check("pend_frame1", frame, 0);
        write_words(32'h62, 4);
        check("pend_cnt", fifo_count, 6);
        check("pend_frame2", frame, 0);
        step();
        check("pend_frame3", frame, 0);
        step();
        expect_beats(32'h60, 6, 0);

        // Hold for three cycles on the second beat.
        write_words(32'h70, 5);
        request(5);
        step();
        check("hold_b0_dat", frame_data, 32'h70);
        check("hold_b0_sof", frame_sof, 1);
        step();
        for (int k = 0; k < 4; k++) begin
            frame_hold = (k < 3);
            check("hold_vld", frame, 1);
            check("hold_dat", frame_data, 32'h71);
            check("hold_sof", frame_sof, 0);
            check("hold_eof", frame_eof, 0);
            step();
        end
        frame_hold = 1'b0;
        expect_beats(32'h70, 5, 2);
        check("hold_cnt", fifo_count, 0);

        // Fill past full: backpressure lags count by one cycle, extra words dropped.
        write_words(32'h100, 29);
        check("bp_cnt29", fifo_count, 29);
        check("bp_lag", frame_bp, 0);
        step();
        check("bp_set", frame_bp, 1);
        write_words(32'h11D, 5);
        check("ovf_cnt", fifo_count, DEPTH);
        check("ovf_err", err_ovf, 1);
        check("ovf_bp", frame_bp, 1);
        request(DEPTH);
        check("ovf_t1", frame, 0);
        step();
        expect_beats(32'h100, DEPTH, 0);
        check("drain_cnt", fifo_count, 0);
        check("drain_bp", frame_bp, 0);
        check("ovf_sticky", err_ovf, 1);

        // Reset on the third beat of an eight-word frame.
        write_words(32'h200, 8);
        request(8);
        step();
        step();
        step();
        check("mid_dat", frame_data, 32'h202);
        rst = 1'b1;
        step();
        check("mid_rst_frame", frame, 0);
        check("mid_rst_cnt", fifo_count, 0);
        check("mid_rst_ovf", err_ovf, 0);
        check("mid_rst_len0", err_len0, 0);
        check("mid_rst_rdy", frame_len_rdy, 0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", frame_len_rdy, 1);
        run_frame('{nw: 3, wbase: 32'h300, len: 3, first: 32'h300, cnt_before: 3, cnt_after: 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_frame_builder.md
# alu_frame_builder

Parametrised successor to the ALU result framer. Buffers ALU result words in an internal FIFO and emits them downstream as length-delimited frames with start/end markers. Downstream can apply hold (backpressure), and the block reports FIFO occupancy and sticky error flags. Sits between the ALU output stage and the downstream packetiser; replaces the fixed 32×32 framer.

## Interface

Parameters:
- DATA_W, 32, ALU word width
- DEPTH, 32, FIFO depth in words; must be a power of 2, minimum 4
- LEN_W, 6, width of the frame-length field; maximum frame length is 2^LEN_W−1
- BP_THRESH, DEPTH−3, occupancy at or above which frame_bp asserts

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- frame_len  input  LEN_W  requested frame length in words
- frame_len_val  input  1  frame request valid
- frame_len_rdy  output  1  request accepted when high with frame_len_val; high only in IDLE
- alu_data  input  DATA_W  ALU result word
- alu_ready  input  1  write strobe for alu_data
- frame  output  1  output beat valid
- frame_data  output  DATA_W  output word
- frame_sof  output  1  first beat of frame
- frame_eof  output  1  last beat of frame
- frame_hold  input  1  downstream not ready; holds the current output beat
- frame_bp  output  1  registered: count ≥ BP_THRESH
- fifo_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
- err_ovf  output  1  sticky: write attempted while full
- err_len0  output  1  sticky: zero-length request accepted

## Operation

- Reset (rst=1 at an edge): state IDLE, pointers 0, fifo_count 0, frame/sof/eof/frame_bp/err_* 0, frame_data 0, frame_len_rdy 0 during the reset cycle. Reset mid-frame flushes the FIFO; the partial frame is lost with no eof.
- FIFO write: alu_ready=1 and count<DEPTH → word stored, wptr+1. At count==DEPTH the word is dropped and err_ovf is set. No write-through to the output.
- Count: log2(DEPTH)+1 bits, so full and empty are distinct. Write and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: frame_len_rdy=1. On accept with len=0, set err_len0 and stay IDLE. On accept with len>0, latch remaining=len, then go to FRAMING if count ≥ len, else to PENDING.
  - PENDING: go to FRAMING when count ≥ remaining. Requests are not accepted.
  - FRAMING: pop one word per cycle when remaining>0 and the output slot is free or being consumed (frame=0 or frame_hold=0), then remaining−1. When the final pop occurs, go to IDLE on the same edge.
- Output register: on a pop, frame=1, frame_data=fifo[rptr], frame_sof=(first pop of frame), frame_eof=(remaining==1).
  - With frame=1 and frame_hold=1, all output fields hold stable.
  - frame clears after the beat is consumed (frame_hold=0) if there is no new pop.
- Length compare uses the registered count, excluding a write in the same cycle.
- frame_bp is independent of state.
- err_* clear only on reset.

## Timing

- Write at edge N → fifo_count reflects it after edge N (visible in cycle N+1).
- Request accepted at edge T with data available → FRAMING in cycle T+1, first pop at edge T+1, frame=frame_sof=1 in cycle T+2.
- Frame of L words with no hold: frame high for L consecutive cycles; sof on the first beat, eof on the last, and both on the same beat when L=1.
- Back-to-back frames: the next request is accepted no earlier than the cycle after eof is popped. This gives at most one idle output cycle between frames when data is ready.
- frame_hold adds exactly one stall cycle per held cycle; no beat is lost or duplicated.
- frame_bp lags fifo_count by one cycle.

## Test plan

- Reset, write 4 words (0xA0..0xA3), request len=4 → frame high 4 cycles starting 2 cycles after accept; data A0..A3; sof on A0, eof on A3; fifo_count returns to 0.
- Request len=6 with 2 words buffered → state PENDING and frame stays 0. Write 4 more words; frame starts 2 cycles after count reaches 6; 6 beats in order.
- Frame len=5, frame_hold high for 3 cycles during beat 2 → beat 2 stable for 4 cycles, then beats 3..5 follow; no loss or duplication.
- Write DEPTH+2 words with no request → fifo_count=DEPTH, err_ovf=1, frame_bp=1. Drain with len=DEPTH: the first DEPTH words are output; pointers wrap.
- Request len=0 → err_len0=1, no frame output, next request accepted the following cycle. Request len=1 → a single beat with sof=eof=1.
- Assert rst mid-frame (beat 3 of 8) → the next cycle has frame=0, fifo_count=0, err_*=0, and a new frame after reset is correct.
